// File: rtl/enc_ctrl.sv
// Sequencing controller that drives one shared parity-row multiplier for the
// (8,4), (16,11) and (32,26) Hamming encoders, one row request at a time.
module enc_ctrl #(
  parameter int unsigned CW_WIDTH   = 32,
  parameter int unsigned INFO_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mod,
  input  logic [INFO_WIDTH-1:0] in_info,
  output logic                  mm_req,
  output logic [1:0]            mm_mod,
  output logic [2:0]            mm_row,
  output logic [CW_WIDTH-1:0]   mm_word,
  input  logic                  mm_valid,
  input  logic                  mm_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW_WIDTH-1:0]   out_codeword,
  output logic [1:0]            out_mod,
  output logic                  err_mod
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

  state_e                r_state, w_state_nxt;
  logic [1:0]            r_mod, w_mod_nxt;
  logic [2:0]            r_row, w_row_nxt;
  logic [CW_WIDTH-1:0]   r_cw, w_cw_nxt;
  logic                  r_err, w_err_nxt;

  logic [INFO_WIDTH-1:0] w_info_masked;
  logic [CW_WIDTH-1:0]   w_load;
  logic [2:0]            w_last_row;

  function automatic logic [2:0] par_bits(input logic [1:0] m);
    case (m)
      2'd0:    par_bits = 3'd4;
      2'd1:    par_bits = 3'd5;
      default: par_bits = 3'd6;
    endcase
  endfunction

  function automatic logic [4:0] info_bits(input logic [1:0] m);
    case (m)
      2'd0:    info_bits = 5'd4;
      2'd1:    info_bits = 5'd11;
      default: info_bits = 5'd26;
    endcase
  endfunction

  // Info is masked to K bits and shifted above the P (still zero) parity slots.
  assign w_info_masked = in_info & ~({INFO_WIDTH{1'b1}} << info_bits(in_mod));
  assign w_load        = CW_WIDTH'(w_info_masked) << par_bits(in_mod);
  assign w_last_row    = par_bits(r_mod) - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_mod   <= 2'd0;
      r_row   <= 3'd0;
      r_cw    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mod   <= w_mod_nxt;
      r_row   <= w_row_nxt;
      r_cw    <= w_cw_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mod_nxt   = r_mod;
    w_row_nxt   = r_row;
    w_cw_nxt    = r_cw;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (in_mod == 2'd3) begin
            w_err_nxt = 1'b1;
          end else begin
            w_mod_nxt   = in_mod;
            w_cw_nxt    = w_load;
            w_row_nxt   = 3'd0;
            w_state_nxt = StIssue;
          end
        end
      end
      StIssue: w_state_nxt = StWait;
      StWait: begin
        if (mm_valid) begin
          w_cw_nxt[r_row] = mm_bit;
          if (r_row == w_last_row) begin
            w_state_nxt = StOut;
          end else begin
            w_row_nxt   = r_row + 3'd1;
            w_state_nxt = StIssue;
          end
        end
      end
      StOut: begin
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign in_ready     = (r_state == StIdle);
  assign mm_req       = (r_state == StIssue);
  assign mm_mod       = r_mod;
  assign mm_row       = r_row;
  assign mm_word      = r_cw;
  assign out_valid    = (r_state == StOut);
  assign out_codeword = r_cw;
  assign out_mod      = r_mod;
  assign err_mod      = r_err;

endmodule

// File: tb/tb_enc_ctrl.sv
// Directed bench for enc_ctrl: a timing model derived from the per-row cost
// checks every cycle, and literal expectations pin the model at key cycles.
module tb_enc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_mod;
  logic [25:0] in_info;
  logic        mm_req;
  logic [1:0]  mm_mod;
  logic [2:0]  mm_row;
  logic [31:0] mm_word;
  logic        mm_valid, mm_bit;
  logic        out_valid, out_ready;
  logic [31:0] out_codeword;
  logic [1:0]  out_mod;
  logic        err_mod;

  enc_ctrl #(.CW_WIDTH(32), .INFO_WIDTH(26)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mod       (in_mod),
    .in_info      (in_info),
    .mm_req       (mm_req),
    .mm_mod       (mm_mod),
    .mm_row       (mm_row),
    .mm_word      (mm_word),
    .mm_valid     (mm_valid),
    .mm_bit       (mm_bit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .out_mod      (out_mod),
    .err_mod      (err_mod)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Row-multiplier stand-in: answers each request after lat cycles with bits_v[row].
  int         lat = 1;
  logic [7:0] bits_v = 8'h00;
  initial begin
    mm_valid = 1'b0;
    mm_bit   = 1'b0;
    forever begin
      @(negedge clk);
      if (mm_req === 1'b1) begin
        automatic int r = int'(mm_row);
        repeat (lat) @(posedge clk);
        #1;
        mm_valid = 1'b1;
        mm_bit   = bits_v[r];
        @(posedge clk);
        #1;
        mm_valid = 1'b0;
        mm_bit   = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d total=%0d bad=%0d", cyc, total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int p_of(input logic [1:0] m);
    return (m == 2'd0) ? 4 : (m == 2'd1) ? 5 : 6;
  endfunction

  function automatic int k_of(input logic [1:0] m);
    return (m == 2'd0) ? 4 : (m == 2'd1) ? 11 : 26;
  endfunction

  // Model: a word accepted in cycle t0 spends 1+lat cycles per row, then sits in output.
  bit          m_busy  = 1'b0;
  int          m_t0, m_lat, m_p;
  logic [1:0]  m_mode;
  logic [31:0] m_base, m_par;
  int          m_err_cyc = -10;

  task automatic compare_cycle();
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_mm_req", 32'(mm_req), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_err_mod", 32'(err_mod), 32'd0);
      chk("rst_mm_word", mm_word, 32'd0);
      chk("rst_mm_row", 32'(mm_row), 32'd0);
      chk("rst_mm_mod", 32'(mm_mod), 32'd0);
      chk("rst_out_codeword", out_codeword, 32'd0);
      chk("rst_out_mod", 32'(out_mod), 32'd0);
      m_busy    = 1'b0;
      m_err_cyc = -10;
      return;
    end
    chk("err_mod", 32'(err_mod), 32'(cyc == m_err_cyc));
    if (!m_busy) begin
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_mm_req", 32'(mm_req), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      if (in_valid) begin
        if (in_mod == 2'd3) begin
          m_err_cyc = cyc + 1;
        end else begin
          m_busy = 1'b1;
          m_t0   = cyc;
          m_mode = in_mod;
          m_lat  = lat;
          m_p    = p_of(in_mod);
          m_base = ((32'(in_info)) & ((32'd1 << k_of(in_mod)) - 32'd1)) << m_p;
          m_par  = 32'(bits_v) & ((32'd1 << m_p) - 32'd1);
        end
      end
    end else begin
      automatic int off  = cyc - m_t0;
      automatic int span = m_p * (1 + m_lat);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      chk("mm_mod", 32'(mm_mod), 32'(m_mode));
      if (off <= span) begin
        automatic int row = (off - 1) / (1 + m_lat);
        chk("mm_req", 32'(mm_req), 32'(((off - 1) % (1 + m_lat)) == 0));
        chk("mm_row", 32'(mm_row), 32'(row));
        chk("mm_word", mm_word, m_base | (m_par & ((32'd1 << row) - 32'd1)));
        chk("row_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_mm_req", 32'(mm_req), 32'd0);
        chk("out_codeword", out_codeword, m_base | m_par);
        chk("out_mod", 32'(out_mod), 32'(m_mode));
        if (out_ready) m_busy = 1'b0;
      end
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  // Leaves the caller at the negedge of cycle c; caller finishes with tick_b().
  task automatic go_to(input int c);
    tick_a();
    while (cyc < c) begin
      tick_b();
      tick_a();
    end
    total++;
    if (cyc != c) begin
      bad++;
      $display("FAIL go_to got=%0d want=%0d", cyc, c);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [25:0] info, output int t0);
    in_valid = 1'b1;
    in_mod   = m;
    in_info  = info;
    t0       = -1;
    for (int i = 0; i < 60; i++) begin
      tick_a();
      if (in_ready) begin
        t0 = cyc;
        tick_b();
        break;
      end
      tick_b();
    end
    in_valid = 1'b0;
    in_mod   = 2'd0;
    in_info  = '0;
    total++;
    if (t0 < 0) begin
      bad++;
      $display("FAIL accept_timeout got=none want=accept");
      t0 = cyc;
    end
  endtask

  initial begin
    int t0;
    int nreq;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mod    = 2'd0;
    in_info   = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Mode 0, L=1, parity 1,0,1,0.
    lat = 1; bits_v = 8'b0000_0101;
    send(2'd0, 26'hB, t0);
    go_to(t0 + 1);
    chk("m0_word_row0", mm_word, 32'h0000_00B0);
    chk("m0_req_first", 32'(mm_req), 32'd1);
    tick_b();
    go_to(t0 + 7);
    chk("m0_word_row3", mm_word, 32'h0000_00B5);
    chk("m0_row3", 32'(mm_row), 32'd3);
    tick_b();
    go_to(t0 + 8);
    chk("m0_not_yet", 32'(out_valid), 32'd0);
    tick_b();
    go_to(t0 + 9);
    chk("m0_out_valid", 32'(out_valid), 32'd1);
    chk("m0_codeword", out_codeword, 32'h0000_00B5);
    tick_b();
    go_to(t0 + 10);
    chk("m0_in_ready_after", 32'(in_ready), 32'd1);
    tick_b();

    // Mode 2, L=1, all ones.
    bits_v = 8'h3F;
    send(2'd2, 26'h3FF_FFFF, t0);
    nreq = 0;
    for (int off = 1; off <= 12; off++) begin
      go_to(t0 + off);
      if (mm_req) nreq++;
      tick_b();
    end
    chk("m2_req_count", 32'(nreq), 32'd6);
    go_to(t0 + 13);
    chk("m2_codeword", out_codeword, 32'hFFFF_FFFF);
    chk("m2_out_mod", 32'(out_mod), 32'd2);
    tick_b();
    tick();

    // Mode 1, L=3, garbage above bit 10.
    lat = 3; bits_v = 8'b0001_0101;
    send(2'd1, 26'h2AB_5FFF, t0);
    go_to(t0 + 20);
    chk("m1_not_yet", 32'(out_valid), 32'd0);
    tick_b();
    go_to(t0 + 21);
    chk("m1_codeword", out_codeword, 32'h0000_FFF5);
    chk("m1_out_mod", 32'(out_mod), 32'd1);
    tick_b();
    tick();

    // Illegal mode, then a normal mode-0 word with L=2.
    send(2'd3, 26'h155_5555, t0);
    go_to(t0 + 1);
    chk("ill_err", 32'(err_mod), 32'd1);
    chk("ill_in_ready", 32'(in_ready), 32'd1);
    chk("ill_no_req", 32'(mm_req), 32'd0);
    tick_b();
    go_to(t0 + 2);
    chk("ill_err_pulse", 32'(err_mod), 32'd0);
    chk("ill_no_req2", 32'(mm_req), 32'd0);
    tick_b();
    lat = 2; bits_v = 8'b0000_1100;
    send(2'd0, 26'h6, t0);
    go_to(t0 + 13);
    chk("ill_next_codeword", out_codeword, 32'h0000_006C);
    chk("ill_next_valid", 32'(out_valid), 32'd1);
    tick_b();
    tick();

    // Backpressure: out_ready low through cycles t0+9..t0+14.
    lat = 1; bits_v = 8'b0000_0011;
    out_ready = 1'b0;
    send(2'd0, 26'h9, t0);
    go_to(t0 + 9);
    chk("bp_codeword_first", out_codeword, 32'h0000_0093);
    tick_b();
    go_to(t0 + 14);
    chk("bp_valid_held", 32'(out_valid), 32'd1);
    chk("bp_codeword_held", out_codeword, 32'h0000_0093);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_no_req", 32'(mm_req), 32'd0);
    tick_b();
    out_ready = 1'b1;
    go_to(t0 + 15);
    chk("bp_handshake_cycle_ready", 32'(in_ready), 32'd0);
    tick_b();
    go_to(t0 + 16);
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_valid_dropped", 32'(out_valid), 32'd0);
    tick_b();

    // Reset during WAIT of row 2; the row-2 answer lands while rst is high.
    lat = 3; bits_v = 8'b0010_1010;
    send(2'd2, 26'h123_4567, t0);
    go_to(t0 + 10);
    chk("rm_row2_wait", 32'(mm_row), 32'd2);
    tick_b();
    rst = 1'b1;
    go_to(t0 + 11);
    chk("rm_word_cleared", mm_word, 32'd0);
    tick_b();
    go_to(t0 + 13);
    tick_b();
    rst = 1'b0;
    go_to(t0 + 14);
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    chk("rm_no_req", 32'(mm_req), 32'd0);
    chk("rm_word_still_zero", mm_word, 32'd0);
    tick_b();
    tick();

    // Normal word after the aborted one.
    lat = 1; bits_v = 8'b0000_1001;
    send(2'd0, 26'h5, t0);
    go_to(t0 + 9);
    chk("post_rst_codeword", out_codeword, 32'h0000_0059);
    tick_b();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
